// File: rtl/sevenseg_pkg.sv
// Shared constants and types for the 8-digit multiplexed 7-segment scanner.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package sevenseg_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int SEG_W      = 7;

  localparam logic [SEG_W-1:0]      SEG_BLANK = 7'h7F;
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = 8'hFF;

  typedef logic [SEG_W-1:0] seg_t;

  typedef enum logic {
    GHOST = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  // Phase counter width: wide enough for the longer of the two phases, at least 1 bit.
  function automatic int cnt_width(input int refresh_div, input int blank_cyc);
    int m;
    m = (refresh_div > blank_cyc) ? refresh_div : blank_cyc;
    if (m < 2) m = 2;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/sevenseg_scan_tick.sv
// Phase counter for the scanner: counts 0..len_m1_i and strobes tc_o on the last count.
// Reused for both the SHOW and GHOST phase lengths.
module scan_tick
  import sevenseg_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] len_m1_i,
  output logic [CNT_W-1:0] cnt_nxt_o,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == len_m1_i);

  always_comb begin
    cnt_d = tc_o ? '0 : cnt_q + 1'b1;
  end

  assign cnt_nxt_o = cnt_d;

  always_ff @(posedge clk_i) begin
    if (clr_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed driver for an 8-digit common-anode 7-segment display with blank gap
// and per-frame snapshot. Define SCAN_DIM_EN to add the bright[2:0] PWM dimming input.
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
`ifdef SCAN_DIM_EN
  input  logic [2:0]            bright,
`endif
  input  seg_t                  d7,
  input  seg_t                  d6,
  input  seg_t                  d5,
  input  seg_t                  d4,
  input  seg_t                  d3,
  input  seg_t                  d2,
  input  seg_t                  d1,
  input  seg_t                  d0,
  output logic [NUM_DIGITS-1:0] an,
  output seg_t                  seg
);

  localparam int CNT_W = cnt_width(REFRESH_DIV, BLANK_CYC);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GHOST_LAST = (BLANK_CYC == 0) ? '0 : CNT_W'(BLANK_CYC - 1);

  scan_state_t           state_q;
  logic [2:0]            idx_q, idx_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  seg_t                  seg_q, seg_d;
  seg_t                  snap_q [NUM_DIGITS];
  seg_t                  d_in   [NUM_DIGITS];
  logic                  clr, tc, enter_show, frame_start, lit;
  logic [CNT_W-1:0]      cnt_nxt, tick_last;
  int                    duty;

  assign d_in[0] = d0;
  assign d_in[1] = d1;
  assign d_in[2] = d2;
  assign d_in[3] = d3;
  assign d_in[4] = d4;
  assign d_in[5] = d5;
  assign d_in[6] = d6;
  assign d_in[7] = d7;

  // Disabling the display is indistinguishable from reset.
  assign clr       = rst | ~enable;
  assign tick_last = (state_q == SHOW) ? SHOW_LAST : GHOST_LAST;

  scan_tick #(.CNT_W(CNT_W)) u_tick (
    .clk_i     (clk),
    .clr_i     (clr),
    .len_m1_i  (tick_last),
    .cnt_nxt_o (cnt_nxt),
    .tc_o      (tc)
  );

  // With no blank gap a finished SHOW re-enters SHOW for the next digit.
  assign enter_show  = tc && ((state_q == GHOST) || (BLANK_CYC == 0));
  assign idx_d       = (tc && (state_q == SHOW)) ? idx_q + 3'd1 : idx_q;
  assign frame_start = enter_show && (idx_d == 3'd0);

`ifdef SCAN_DIM_EN
  logic [2:0] bright_q, bright_eff;
  // The brightness for a new frame is taken live on the edge it is captured.
  assign bright_eff = frame_start ? bright : bright_q;
  assign duty       = (int'(bright_eff) + 1) * (REFRESH_DIV / 8);
`else
  assign duty = REFRESH_DIV;
`endif

  assign lit = int'(cnt_nxt) < duty;

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    if (enter_show || ((state_q == SHOW) && !tc)) begin
      an_d  = lit ? ~(NUM_DIGITS'(1) << idx_d) : AN_OFF;
      seg_d = frame_start ? d_in[0] : snap_q[idx_d];
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= GHOST;
      idx_q   <= '0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_BLANK;
      for (int i = 0; i < NUM_DIGITS; i++) snap_q[i] <= SEG_BLANK;
`ifdef SCAN_DIM_EN
      bright_q <= 3'd7;
`endif
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      idx_q <= idx_d;
      if (tc) state_q <= enter_show ? SHOW : GHOST;
      if (frame_start) begin
        for (int i = 0; i < NUM_DIGITS; i++) snap_q[i] <= d_in[i];
`ifdef SCAN_DIM_EN
        bright_q <= bright;
`endif
      end
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Directed bench for sevenseg_scan: one instance with a blank gap, one without, both
// compared every cycle against a frame-position model through a scoreboard queue.
module tb_sevenseg_scan;
  import sevenseg_pkg::*;

`ifdef SCAN_DIM_EN
  localparam int RD = 8;
`else
  localparam int RD = 4;
`endif
  localparam int BL  = 2;
  localparam int SL  = RD + BL;
  localparam int FRM = 8 * SL;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b1;
`ifdef SCAN_DIM_EN
  logic [2:0] bright = 3'd7;
  logic [2:0] mbr [2];
`endif
  seg_t d [8];
  logic [7:0] an_a, an_b;
  seg_t seg_a, seg_b;

  int errors = 0;
  int checks = 0;
  int t = 0;
  int mp [2];
  seg_t msnap [2][8];
  logic [14:0] q_a [$];
  logic [14:0] q_b [$];

  always #5 clk = ~clk;

  sevenseg_scan #(.REFRESH_DIV(RD), .BLANK_CYC(BL)) u_dut (
    .clk(clk), .rst(rst), .enable(enable),
`ifdef SCAN_DIM_EN
    .bright(bright),
`endif
    .d7(d[7]), .d6(d[6]), .d5(d[5]), .d4(d[4]),
    .d3(d[3]), .d2(d[2]), .d1(d[1]), .d0(d[0]),
    .an(an_a), .seg(seg_a)
  );

  sevenseg_scan #(.REFRESH_DIV(RD), .BLANK_CYC(0)) u_dut0 (
    .clk(clk), .rst(rst), .enable(enable),
`ifdef SCAN_DIM_EN
    .bright(bright),
`endif
    .d7(d[7]), .d6(d[6]), .d5(d[5]), .d4(d[4]),
    .d3(d[3]), .d2(d[2]), .d1(d[1]), .d0(d[0]),
    .an(an_b), .seg(seg_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h required=%0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  // Model position: -1 is the extra reset cycle of the gapless build, b marks digit-0 entry.
  task automatic model_edge(input int k, input int b);
    if (rst || !enable) begin
      mp[k] = (b == 0) ? -1 : 0;
      for (int i = 0; i < 8; i++) msnap[k][i] = 7'h7F;
    end else begin
      mp[k] = (mp[k] + 1) % (8 * (RD + b));
      if (mp[k] == b) begin
        for (int i = 0; i < 8; i++) msnap[k][i] = d[i];
`ifdef SCAN_DIM_EN
        mbr[k] = bright;
`endif
      end
    end
  endtask

  function automatic logic [14:0] model_out(input int k, input int b);
    int slot, off, dty;
    logic [7:0] a;
    if (mp[k] < 0) return {8'hFF, 7'h7F};
    slot = mp[k] / (RD + b);
    off  = mp[k] % (RD + b);
    if (off < b) return {8'hFF, 7'h7F};
`ifdef SCAN_DIM_EN
    dty = (int'(mbr[k]) + 1) * (RD / 8);
`else
    dty = RD;
`endif
    a = 8'hFF;
    if (off - b < dty) a[slot] = 1'b0;
    return {a, msnap[k][slot]};
  endfunction

  task automatic step();
    logic [14:0] ea, eb;
    @(posedge clk);
    model_edge(0, BL);
    q_a.push_back(model_out(0, BL));
    model_edge(1, 0);
    q_b.push_back(model_out(1, 0));
    @(negedge clk);
    t++;
    ea = q_a.pop_front();
    eb = q_b.pop_front();
    chk("scan_gap",   32'({an_a, seg_a}), 32'(ea));
    chk("scan_nogap", 32'({an_b, seg_b}), 32'(eb));
    chk("onehot_gap",   32'($countones(~an_a) <= 1), 32'd1);
    chk("onehot_nogap", 32'($countones(~an_b) <= 1), 32'd1);
  endtask

  task automatic chk_out(input string tag, input logic [7:0] ea, input logic [6:0] es);
    chk(tag, 32'({an_a, seg_a}), 32'({ea, es}));
  endtask

  task automatic hold_chk(input string tag, input logic [7:0] ea, input logic [6:0] es, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk_out(tag, ea, es);
    end
  endtask

  task automatic run_to(input int target);
    while (t < target) step();
  endtask

  // First cycle (relative to restart) at which digit k of frame f is lit on the gapped instance.
  function automatic int shw(input int f, input int k);
    return f * FRM + k * SL + BL;
  endfunction

  task automatic count_lit(input int k, output int n);
    logic [7:0] ea;
    ea = 8'hFF;
    ea[k] = 1'b0;
    n = 0;
    for (int i = 0; i < RD; i++) begin
      step();
      if (an_a === ea) n++;
    end
  endtask

  initial begin
    logic [7:0] exp_an;
    int n;
    d[0] = 7'h40; d[1] = 7'h79; d[2] = 7'h24; d[3] = 7'h30;
    d[4] = 7'h19; d[5] = 7'h12; d[6] = 7'h02; d[7] = 7'h78;

    // Reset, then first frame.
    repeat (3) step();
    chk_out("reset", 8'hFF, 7'h7F);
    rst = 1'b0;
    t = 0;
    hold_chk("f1_gap0", 8'hFF, 7'h7F, BL - 1);
    hold_chk("f1_dig0", 8'hFE, 7'h40, RD);
    hold_chk("f1_gap1", 8'hFF, 7'h7F, BL);
    hold_chk("f1_dig1", 8'hFD, 7'h79, RD);

    // Change d5 while digit 2 is lit; snapshot must hold until the next frame.
    run_to(shw(0, 2) + 1);
    d[5] = 7'h24;
    run_to(shw(0, 5));
    chk_out("tear_cur", 8'hDF, 7'h12);
    run_to(shw(0, 7));
    chk_out("wrap_d7", 8'h7F, 7'h78);
    run_to(FRM - 1);
    chk_out("wrap_d7_end", 8'h7F, 7'h78);
    hold_chk("wrap_gap", 8'hFF, 7'h7F, BL);
    hold_chk("wrap_d0", 8'hFE, 7'h40, 1);
    run_to(shw(1, 5));
    chk_out("tear_next", 8'hDF, 7'h24);

    // One-cycle enable drop mid-SHOW of digit 4.
    run_to(shw(2, 4) + 1);
    chk_out("pre_en", 8'hEF, 7'h19);
    enable = 1'b0;
    step();
    chk_out("en_off", 8'hFF, 7'h7F);
    enable = 1'b1;
    t = 0;
    hold_chk("en_gap", 8'hFF, 7'h7F, BL - 1);
    hold_chk("en_dig0", 8'hFE, 7'h40, RD);

    // Same via rst.
    run_to(shw(0, 4) + 1);
    chk_out("pre_rst", 8'hEF, 7'h19);
    rst = 1'b1;
    step();
    chk_out("rst_mid", 8'hFF, 7'h7F);
    rst = 1'b0;
    t = 0;

    // Gapless instance steps through every digit with no all-off cycle.
    for (int s = 0; s < 9; s++) begin
      for (int c = 0; c < RD; c++) begin
        step();
        exp_an = 8'hFF;
        exp_an[s % 8] = 1'b0;
        chk("nogap_an", 32'(an_b), 32'(exp_an));
        if (t < SL) chk("rst_restart", 32'(an_a), (t < BL) ? 32'hFF : 32'hFE);
      end
    end

`ifdef SCAN_DIM_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    t = 0;
    run_to(shw(0, 2));
    bright = 3'd1;
    run_to(shw(0, 3) - 1);
    count_lit(3, n);
    chk("dim_full_cur", 32'(n), 32'(RD));
    run_to(shw(1, 3) - 1);
    count_lit(3, n);
    chk("dim_b1", 32'(n), 32'(2 * (RD / 8)));
    bright = 3'd7;
    run_to(shw(1, 5) - 1);
    count_lit(5, n);
    chk("dim_hold", 32'(n), 32'(2 * (RD / 8)));
    run_to(shw(2, 3) - 1);
    count_lit(3, n);
    chk("dim_b7", 32'(n), 32'(RD));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
